// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - sram-like data port bundle between CPU (master) and data memory (slave)
interface data_sram_resp_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output en,
    output wen,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  wen,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-side sram-like responder: byte-writable word RAM plus LED/switch/timer/compare MMIO
// Reads are registered at the request edge (and once more when READ_LAT=2); the timer interrupt is a level.
module data_sram_resp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          READ_LAT   = 1,
  parameter logic [31:0] MMIO_BASE  = 32'h1faf_0000,
  parameter logic [31:0] MMIO_MASK  = 32'hffff_0000
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_sram_resp_if.slave        bus,
  input  logic [7:0]             switch_i,
  output logic [15:0]            led_o,
  output logic                   int_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic [15:0]           r_led;
  logic [31:0]           r_timer;
  logic [31:0]           r_compare;
  logic                  r_int;
  logic [7:0]            r_sw_meta;
  logic [7:0]            r_sw_sync;

  logic                  w_mmio;
  logic                  w_req_rd;
  logic                  w_ram_wr;
  logic                  w_mmio_wr;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_off;
  logic [31:0]           w_bmask;
  logic                  w_led_we;
  logic                  w_timer_we;
  logic                  w_cmp_we;
  logic [31:0]           w_timer_nxt;
  logic [31:0]           w_cmp_nxt;
  logic [31:0]           w_led_nxt;
  logic [31:0]           w_rd_val;

  assign w_mmio    = (bus.addr & MMIO_MASK) == MMIO_BASE;
  assign w_req_rd  = bus.en && (bus.wen == 4'b0000);
  assign w_ram_wr  = bus.en && (bus.wen != 4'b0000) && !w_mmio;
  assign w_mmio_wr = bus.en && (bus.wen != 4'b0000) && w_mmio;
  assign w_idx     = bus.addr[DEPTH_LOG2+1:2];
  assign w_off     = bus.addr[3:2];
  assign w_bmask   = {{8{bus.wen[3]}}, {8{bus.wen[2]}}, {8{bus.wen[1]}}, {8{bus.wen[0]}}};

  assign w_led_we   = w_mmio_wr && (w_off == 2'd0);
  assign w_timer_we = w_mmio_wr && (w_off == 2'd2);
  assign w_cmp_we   = w_mmio_wr && (w_off == 2'd3);

  assign w_led_nxt   = ({16'h0, r_led} & ~w_bmask) | (bus.wdata & w_bmask);
  assign w_cmp_nxt   = (r_compare & ~w_bmask) | (bus.wdata & w_bmask);
  // A software load of TIMER takes priority over the free-running increment.
  assign w_timer_nxt = w_timer_we ? ((r_timer & ~w_bmask) | (bus.wdata & w_bmask))
                                  : r_timer + 32'd1;

  // RAM has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wen[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led     <= 16'h0;
      r_timer   <= 32'h0;
      r_compare <= 32'h0;
      r_int     <= 1'b0;
      r_sw_meta <= 8'h0;
      r_sw_sync <= 8'h0;
    end else begin
      r_sw_meta <= switch_i;
      r_sw_sync <= r_sw_meta;
      r_timer   <= w_timer_nxt;
      if (w_led_we) begin
        r_led <= w_led_nxt[15:0];
      end
      if (w_cmp_we) begin
        r_compare <= w_cmp_nxt;
      end
      // The interrupt rises on the edge TIMER reaches COMPARE; a COMPARE write always clears it.
      if (w_cmp_we) begin
        r_int <= 1'b0;
      end else if ((w_timer_nxt == r_compare) && (r_compare != 32'h0)) begin
        r_int <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_val = r_mem[w_idx];
    if (w_mmio) begin
      case (w_off)
        2'd0:    w_rd_val = {16'h0, r_led};
        2'd1:    w_rd_val = {24'h0, r_sw_sync};
        2'd2:    w_rd_val = r_timer;
        default: w_rd_val = r_compare;
      endcase
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        r_s1_vld;
      logic [31:0] r_s1_data;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_s1_vld  <= 1'b0;
          r_s1_data <= 32'h0;
          r_rdata   <= 32'h0;
        end else begin
          r_s1_vld <= w_req_rd;
          if (w_req_rd) begin
            r_s1_data <= w_rd_val;
          end
          if (r_s1_vld) begin
            r_rdata <= r_s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_rdata <= 32'h0;
        end else if (w_req_rd) begin
          r_rdata <= w_rd_val;
        end
      end
    end
  endgenerate

  assign bus.rdata = r_rdata;
  assign led_o     = r_led;
  assign int_o     = r_int;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - scoreboard bench driving one request stream into READ_LAT=1 and READ_LAT=2 instances
module tb_data_sram_resp;

  localparam logic [31:0] LED = 32'h1faf_0000;
  localparam logic [31:0] SW  = 32'h1faf_0004;
  localparam logic [31:0] TIM = 32'h1faf_0008;
  localparam logic [31:0] CMP = 32'h1faf_000C;

  typedef struct {
    int          due;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [7:0]  switch_i;
  logic [15:0] led1, led2;
  logic        int1, int2;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          e;
  exp_t        q1[$];
  exp_t        q2[$];

  data_sram_resp_if b1();
  data_sram_resp_if b2();

  assign b1.en = en;  assign b1.wen = wen;  assign b1.addr = addr;  assign b1.wdata = wdata;
  assign b2.en = en;  assign b2.wen = wen;  assign b2.addr = addr;  assign b2.wdata = wdata;

  data_sram_resp #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave), .switch_i(switch_i), .led_o(led1), .int_o(int1)
  );
  data_sram_resp #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .resetn(resetn), .bus(b2.slave), .switch_i(switch_i), .led_o(led2), .int_o(int2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due <= cyc) begin
      exp_t x;
      x = q1.pop_front();
      if (x.due < cyc) chk({"lat1 late ", x.name}, 32'hdead_0000, x.val);
      else             chk({"lat1 ", x.name}, b1.rdata, x.val);
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].due <= cyc) begin
      exp_t x;
      x = q2.pop_front();
      if (x.due < cyc) chk({"lat2 late ", x.name}, 32'hdead_0000, x.val);
      else             chk({"lat2 ", x.name}, b2.rdata, x.val);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      en = 1'b0; wen = 4'b0000;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    en = 1'b1; wen = be; addr = a; wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    en = 1'b1; wen = 4'b0000; addr = a; wdata = 32'h0;
    q1.push_back('{due: cyc + 1, val: exp, name: nm});
    q2.push_back('{due: cyc + 2, val: exp, name: nm});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'b0; addr = 32'h0; wdata = 32'h0; switch_i = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata1", b1.rdata, 32'h0);
    chk("reset rdata2", b2.rdata, 32'h0);
    chk("reset led", {16'h0, led1}, 32'h0);
    chk("reset int", {31'h0, int1 | int2}, 32'h0);
    resetn = 1'b1;

    wr(32'h40, 32'h1122_3344, 4'b1111);
    rd(32'h40, 32'h1122_3344, "full word");
    wr(32'h40, 32'hAABB_CCDD, 4'b0010);
    rd(32'h40, 32'h1122_CC44, "byte lane 1");
    rd(32'h4040, 32'h1122_CC44, "ram alias");
    wr(32'h80, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h80, 32'hDEAD_BEEF, "raw next cycle");
    wr(32'h84, 32'h0000_000A, 4'b1111);
    wr(32'h88, 32'h0000_000B, 4'b1111);
    wr(32'h8C, 32'h0000_000C, 4'b1111);
    rd(32'h84, 32'h0000_000A, "b2b A");
    rd(32'h88, 32'h0000_000B, "b2b B");
    rd(32'h8C, 32'h0000_000C, "b2b C");
    idle(3);

    wr(LED, 32'hFFFF_A5A5, 4'b1111);
    idle(1);
    chk("led_o lat1", {16'h0, led1}, 32'h0000_A5A5);
    chk("led_o lat2", {16'h0, led2}, 32'h0000_A5A5);
    rd(32'h1faf_1230, 32'h0000_A5A5, "led readback alias");
    switch_i = 8'h3C;
    idle(3);
    rd(SW, 32'h0000_003C, "switch");
    wr(SW, 32'hFFFF_FFFF, 4'b1111);
    rd(SW, 32'h0000_003C, "switch write ignored");
    idle(2);

    wr(CMP, 32'd20, 4'b1111);
    wr(TIM, 32'd10, 4'b1111);
    e = cyc + 1;
    idle(1);
    while (cyc < e + 9) idle(1);
    chk("int before match", {31'h0, int1 | int2}, 32'h0);
    idle(1);
    chk("int at match lat1", {31'h0, int1}, 32'h1);
    chk("int at match lat2", {31'h0, int2}, 32'h1);
    idle(3);
    chk("int held", {31'h0, int1 & int2}, 32'h1);
    wr(CMP, 32'h0, 4'b1111);
    idle(1);
    chk("int cleared", {31'h0, int1 | int2}, 32'h0);
    wr(TIM, 32'hFFFF_FFFF, 4'b1111);
    idle(1);
    rd(TIM, 32'h0, "timer wrap 0");
    rd(TIM, 32'h1, "timer wrap 1");
    idle(4);

    @(posedge clk); #1;
    en = 1'b1; wen = 4'b0000; addr = 32'h40;
    @(posedge clk); #1;
    resetn = 1'b0; en = 1'b0;
    #1;
    chk("async reset rdata1", b1.rdata, 32'h0);
    chk("async reset rdata2", b2.rdata, 32'h0);
    idle(3);
    @(posedge clk); #1;
    resetn = 1'b1;
    en = 1'b1; wen = 4'b0000; addr = TIM;
    q1.push_back('{due: cyc + 1, val: 32'h0, name: "timer after reset"});
    q2.push_back('{due: cyc + 2, val: 32'h0, name: "timer after reset"});
    @(posedge clk); #1;
    en = 1'b0;
    chk("no stale return", b2.rdata, 32'h0);
    chk("led after reset", {16'h0, led1}, 32'h0);
    chk("int after reset", {31'h0, int1 | int2}, 32'h0);
    idle(4);

    for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
    if (q1.size() > 0 || q2.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
